// File: rtl/unidade_controle_rodadas_if.sv
// Control-side bundle between the round controller and the game datapath/top level.
// The controller is the slave; the datapath/top level is the master.
interface unidade_controle_rodadas_if;
    logic       iniciar;
    logic       jogada;
    logic       igual;
    logic       fimE;
    logic       fimL;
    logic       zeraE;
    logic       contaE;
    logic       zeraL;
    logic       contaL;
    logic       zeraR;
    logic       registraR;
    logic       pronto;
    logic       ganhou;
    logic       perdeu;
    logic       timeout;
    logic [3:0] db_estado;

    modport master (
        output iniciar, jogada, igual, fimE, fimL,
        input  zeraE, contaE, zeraL, contaL, zeraR, registraR,
        input  pronto, ganhou, perdeu, timeout, db_estado
    );

    modport slave (
        input  iniciar, jogada, igual, fimE, fimL,
        output zeraE, contaE, zeraL, contaL, zeraR, registraR,
        output pronto, ganhou, perdeu, timeout, db_estado
    );
endinterface

// File: rtl/unidade_controle_rodadas.sv
// Moore control unit for the round-based memory game.
// It sequences the E/L counters and the play register and ends the game on a per-play timeout.
module unidade_controle_rodadas #(
    parameter int TIMEOUT = 5000,
    parameter int TW      = 16
) (
    input logic                        clock,
    input logic                        reset,
    unidade_controle_rodadas_if.slave  bus
);

    typedef enum logic [3:0] {
        st_inicial        = 4'h0,
        st_preparacao     = 4'h1,
        st_inicio_rodada  = 4'h2,
        st_espera_jogada  = 4'h3,
        st_registra       = 4'h4,
        st_comparacao     = 4'h5,
        st_proxima_rodada = 4'h6,
        st_proxima_jogada = 4'h7,
        st_fim_acertou    = 4'hA,
        st_fim_errou      = 4'hE,
        st_fim_timeout    = 4'hC
    } estado_t;

    localparam logic [TW-1:0] LIMITE = TW'(TIMEOUT - 1);

    estado_t       estado;
    estado_t       proximo;
    logic [TW-1:0] timer;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= st_inicial;
        end else begin
            estado <= proximo;
        end
    end

    // The timer only runs while staying in espera_jogada, so every entry starts from 0.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timer <= '0;
        end else if (estado == st_espera_jogada && proximo == st_espera_jogada) begin
            timer <= timer + 1'b1;
        end else begin
            timer <= '0;
        end
    end

    always_comb begin
        proximo = st_inicial;
        case (estado)
            st_inicial:        proximo = bus.iniciar ? st_preparacao : st_inicial;
            st_preparacao:     proximo = st_inicio_rodada;
            st_inicio_rodada:  proximo = st_espera_jogada;
            st_espera_jogada: begin
                // A play arriving on the last allowed cycle still wins over the timeout.
                if (bus.jogada)          proximo = st_registra;
                else if (timer == LIMITE) proximo = st_fim_timeout;
                else                     proximo = st_espera_jogada;
            end
            st_registra:       proximo = st_comparacao;
            st_comparacao: begin
                if (!bus.igual)     proximo = st_fim_errou;
                else if (!bus.fimE) proximo = st_proxima_jogada;
                else if (!bus.fimL) proximo = st_proxima_rodada;
                else                proximo = st_fim_acertou;
            end
            st_proxima_jogada: proximo = st_espera_jogada;
            st_proxima_rodada: proximo = st_inicio_rodada;
            st_fim_acertou:    proximo = bus.iniciar ? st_preparacao : st_fim_acertou;
            st_fim_errou:      proximo = bus.iniciar ? st_preparacao : st_fim_errou;
            st_fim_timeout:    proximo = bus.iniciar ? st_preparacao : st_fim_timeout;
            default:           proximo = st_inicial;
        endcase
    end

    always_comb begin
        bus.zeraE     = (estado == st_preparacao) || (estado == st_inicio_rodada);
        bus.zeraL     = (estado == st_inicial) || (estado == st_preparacao);
        bus.zeraR     = (estado == st_inicial) || (estado == st_preparacao) ||
                        (estado == st_inicio_rodada);
        bus.registraR = (estado == st_registra);
        bus.contaE    = (estado == st_proxima_jogada);
        bus.contaL    = (estado == st_proxima_rodada);
        bus.ganhou    = (estado == st_fim_acertou);
        bus.timeout   = (estado == st_fim_timeout);
        bus.perdeu    = (estado == st_fim_errou) || (estado == st_fim_timeout);
        bus.pronto    = (estado == st_fim_acertou) || (estado == st_fim_errou) ||
                        (estado == st_fim_timeout);
    end

    // Unused encodings read back as F so a corrupted state is visible on the debug port.
    always_comb begin
        case (estado)
            st_inicial, st_preparacao, st_inicio_rodada, st_espera_jogada,
            st_registra, st_comparacao, st_proxima_rodada, st_proxima_jogada,
            st_fim_acertou, st_fim_errou, st_fim_timeout: bus.db_estado = estado;
            default:                                      bus.db_estado = 4'hF;
        endcase
    end

endmodule

// File: tb/tb_unidade_controle_rodadas.sv
// Bench for the round controller: per-cycle expected output words are queued by the drivers
// and compared on the falling edge; scenario tasks add targeted inline checks.
module tb_unidade_controle_rodadas;

    localparam int TIMEOUT = 8;
    localparam int TW      = 16;

    logic clock;
    logic reset;

    unidade_controle_rodadas_if bus ();

    unidade_controle_rodadas #(
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [13:0] exp_q[$];
    int          checks;
    int          errors;
    int          cnt_contae;
    int          cnt_contal;
    int          cnt_regr;
    logic [13:0] out_vec;

    assign out_vec = {bus.zeraE, bus.contaE, bus.zeraL, bus.contaL, bus.zeraR, bus.registraR,
                      bus.pronto, bus.ganhou, bus.perdeu, bus.timeout, bus.db_estado};

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected output word for a state, straight from the output table.
    function automatic logic [13:0] exp_vec(input logic [3:0] st);
        logic ze, ce, zl, cl, zr, rr, pr, gn, pd, to;
        ze = (st == 4'h1) || (st == 4'h2);
        ce = (st == 4'h7);
        zl = (st == 4'h0) || (st == 4'h1);
        cl = (st == 4'h6);
        zr = (st == 4'h0) || (st == 4'h1) || (st == 4'h2);
        rr = (st == 4'h4);
        pr = (st == 4'hA) || (st == 4'hE) || (st == 4'hC);
        gn = (st == 4'hA);
        pd = (st == 4'hE) || (st == 4'hC);
        to = (st == 4'hC);
        return {ze, ce, zl, cl, zr, rr, pr, gn, pd, to, st};
    endfunction

    function automatic logic [3:0] decide(input logic ig, input logic fe, input logic fl);
        if (!ig)      return 4'hE;
        else if (!fe) return 4'h7;
        else if (!fl) return 4'h6;
        else          return 4'hA;
    endfunction

    // scoreboard: one expected word per driven cycle, compared mid-cycle
    always @(negedge clock) begin
        logic [13:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (out_vec !== e) begin
                errors++;
                $display("FAIL cycle_outputs t=%0t got=%h expected=%h", $time, out_vec, e);
            end
        end
        if (bus.contaE === 1'b1)    cnt_contae++;
        if (bus.contaL === 1'b1)    cnt_contal++;
        if (bus.registraR === 1'b1) cnt_regr++;
    end

    // driver: called at posedge+1 with inputs set for the current cycle
    task automatic cyc(input logic [3:0] st);
        exp_q.push_back(exp_vec(st));
        @(posedge clock);
        #1;
    endtask

    task automatic start_game(input logic [3:0] cur);
        bus.iniciar = 1'b1;
        cyc(cur);
        bus.iniciar = 1'b0;
        cyc(4'h1);
        cyc(4'h2);
    endtask

    // One play from an espera_jogada cycle; leaves the bench in espera_jogada or an end state.
    task automatic play(input logic ig, input logic fe, input logic fl, output logic [3:0] nx);
        bus.jogada = 1'b1;
        cyc(4'h3);
        bus.jogada = 1'b0;
        cyc(4'h4);
        bus.igual = ig;
        bus.fimE  = fe;
        bus.fimL  = fl;
        cyc(4'h5);
        bus.igual = 1'b0;
        bus.fimE  = 1'b0;
        bus.fimL  = 1'b0;
        nx = decide(ig, fe, fl);
        if (nx == 4'h7) begin
            cyc(4'h7);
        end else if (nx == 4'h6) begin
            cyc(4'h6);
            cyc(4'h2);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (out_vec !== exp_vec(4'h0)) begin
            errors++;
            $display("FAIL reset_initial got=%h expected=%h", out_vec, exp_vec(4'h0));
        end
        start_game(4'h0);
        repeat (3) cyc(4'h3);
        checks++;
        if (dut.timer !== 16'd3) begin
            errors++;
            $display("FAIL timer_before_reset got=%0d expected=3", dut.timer);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (out_vec !== exp_vec(4'h0)) begin
            errors++;
            $display("FAIL async_reset_outputs got=%h expected=%h", out_vec, exp_vec(4'h0));
        end
        checks++;
        if (dut.timer !== 16'd0) begin
            errors++;
            $display("FAIL async_reset_timer got=%0d expected=0", dut.timer);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        cyc(4'h0);
        checks++;
        if (bus.db_estado !== 4'h0) begin
            errors++;
            $display("FAIL reset_release_idle got=%h expected=0", bus.db_estado);
        end
    endtask

    task automatic test_round0();
        int regr0, conl0;
        logic [3:0] nx;
        start_game(4'h0);
        regr0 = cnt_regr;
        conl0 = cnt_contal;
        play(1'b1, 1'b1, 1'b0, nx);
        checks++;
        if (cnt_regr - regr0 != 1) begin
            errors++;
            $display("FAIL round0_registraR_cycles got=%0d expected=1", cnt_regr - regr0);
        end
        checks++;
        if (cnt_contal - conl0 != 1) begin
            errors++;
            $display("FAIL round0_contaL_cycles got=%0d expected=1", cnt_contal - conl0);
        end
    endtask

    task automatic test_three_plays();
        int ce0, cl0;
        logic [3:0] nx;
        ce0 = cnt_contae;
        cl0 = cnt_contal;
        play(1'b1, 1'b0, 1'b0, nx);
        play(1'b1, 1'b0, 1'b0, nx);
        play(1'b1, 1'b1, 1'b0, nx);
        checks++;
        if (cnt_contae - ce0 != 2) begin
            errors++;
            $display("FAIL three_plays_contaE got=%0d expected=2", cnt_contae - ce0);
        end
        checks++;
        if (cnt_contal - cl0 != 1) begin
            errors++;
            $display("FAIL three_plays_contaL got=%0d expected=1", cnt_contal - cl0);
        end
        play(1'b1, 1'b1, 1'b1, nx);
        checks++;
        if ({bus.pronto, bus.ganhou, bus.perdeu, bus.db_estado} !== {3'b110, 4'hA}) begin
            errors++;
            $display("FAIL final_round_win got=%b%b%b/%h expected=110/a",
                     bus.pronto, bus.ganhou, bus.perdeu, bus.db_estado);
        end
        cyc(4'hA);
    endtask

    task automatic test_wrong_play();
        logic [3:0] nx;
        start_game(4'hA);
        play(1'b0, 1'b1, 1'b1, nx);
        checks++;
        if ({bus.pronto, bus.perdeu, bus.ganhou, bus.timeout, bus.db_estado} !== {4'b1100, 4'hE}) begin
            errors++;
            $display("FAIL wrong_play_end got=%b%b%b%b/%h expected=1100/e",
                     bus.pronto, bus.perdeu, bus.ganhou, bus.timeout, bus.db_estado);
        end
        cyc(4'hE);
        bus.iniciar = 1'b1;
        cyc(4'hE);
        bus.iniciar = 1'b0;
        checks++;
        if (bus.db_estado !== 4'h1) begin
            errors++;
            $display("FAIL restart_from_errou got=%h expected=1", bus.db_estado);
        end
        cyc(4'h1);
        cyc(4'h2);
    endtask

    task automatic test_timeout();
        logic [3:0] nx;
        repeat (TIMEOUT) cyc(4'h3);
        checks++;
        if ({bus.timeout, bus.perdeu, bus.pronto, bus.db_estado} !== {3'b111, 4'hC}) begin
            errors++;
            $display("FAIL timeout_end got=%b%b%b/%h expected=111/c",
                     bus.timeout, bus.perdeu, bus.pronto, bus.db_estado);
        end
        cyc(4'hC);
        start_game(4'hC);
        repeat (TIMEOUT - 1) cyc(4'h3);
        checks++;
        if (dut.timer !== 16'(TIMEOUT - 1)) begin
            errors++;
            $display("FAIL timer_last_cycle got=%0d expected=%0d", dut.timer, TIMEOUT - 1);
        end
        play(1'b1, 1'b0, 1'b0, nx);
    endtask

    task automatic test_timer_restart();
        logic [3:0] nx;
        repeat (TIMEOUT - 2) cyc(4'h3);
        play(1'b1, 1'b0, 1'b0, nx);
        checks++;
        if (dut.timer !== 16'd0) begin
            errors++;
            $display("FAIL timer_restart_entry got=%0d expected=0", dut.timer);
        end
        repeat (TIMEOUT) cyc(4'h3);
        checks++;
        if (bus.db_estado !== 4'hC) begin
            errors++;
            $display("FAIL timer_restart_timeout got=%h expected=c", bus.db_estado);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] cur, nx;
        logic       ended;
        cur = 4'hC;
        for (int g = 0; g < 4; g++) begin
            start_game(cur);
            ended = 1'b0;
            for (int p = 0; p < 16 && !ended; p++) begin
                // comparator inputs are noise outside comparacao
                repeat ($urandom_range(0, TIMEOUT - 2)) begin
                    bus.igual = 1'($urandom_range(0, 1));
                    bus.fimE  = 1'($urandom_range(0, 1));
                    bus.fimL  = 1'($urandom_range(0, 1));
                    cyc(4'h3);
                end
                play(($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), nx);
                if (nx == 4'hA || nx == 4'hE) begin
                    ended = 1'b1;
                    cur = nx;
                end
            end
            if (!ended) begin
                repeat (TIMEOUT) cyc(4'h3);
                cur = 4'hC;
            end
            cyc(cur);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        cnt_contae  = 0;
        cnt_contal  = 0;
        cnt_regr    = 0;
        reset       = 1'b0;
        bus.iniciar = 1'b0;
        bus.jogada  = 1'b0;
        bus.igual   = 1'b0;
        bus.fimE    = 1'b0;
        bus.fimL    = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;

        test_reset();
        test_round0();
        test_three_plays();
        test_wrong_play();
        test_timeout();
        test_timer_restart();
        test_back_to_back();

        @(negedge clock);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
